// File: rtl/pgm_sprite_linebuf.sv
// pgm_sprite_linebuf: double-buffered sprite line buffer.
// Fetches packed 5bpp A-ROM words over DDRAM, draws opaque pixels into the
// back bank (first writer wins) and serves the front bank to the mixer.
module pgm_sprite_linebuf #(
  parameter int unsigned LINE_W    = 448,
  parameter logic [28:0] AROM_BASE = 29'h0400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_x,
  input  logic [8:0]  cmd_w,
  input  logic [4:0]  cmd_pal,
  input  logic        cmd_flip,
  input  logic [25:0] cmd_addr,
  output logic        ddram_rd,
  output logic [28:0] ddram_addr,
  input  logic        ddram_busy,
  input  logic [63:0] ddram_dout,
  input  logic        ddram_dout_ready,
  input  logic [8:0]  rd_x,
  output logic [9:0]  rd_pix,
  output logic        rd_opaque,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_WRITE} state_t;

  state_t            state_q, state_d;
  logic              bank_q, bank_d;         // index of the back (draw) bank
  logic              rd_pend_q, rd_pend_d;   // a DDRAM read is outstanding
  logic [10:0]       x_q, x_d;
  logic [8:0]        w_q, w_d;
  logic [4:0]        pal_q, pal_d;
  logic              flip_q, flip_d;
  logic [25:0]       addr_q, addr_d;
  logic [8:0]        i_q, i_d;               // pixel counter within the command
  logic [5:0]        k_q, k_d;               // word counter within the command
  logic [3:0]        j_q, j_d;               // pixel slot within the current word
  logic [59:0]       word_q, word_d;         // 12 pixels, P0 in the low bits
  logic              ddram_rd_q, ddram_rd_d;
  logic [28:0]       ddram_addr_q, ddram_addr_d;
  logic              busy_q, busy_d;
  logic [9:0]        rd_pix_q, rd_pix_d;
  logic              rd_opaque_q, rd_opaque_d;
  logic [LINE_W-1:0] opq_q [2];
  logic [LINE_W-1:0] opq_d [2];
  logic [9:0]        pix_mem [2][LINE_W];

  logic [4:0]        px_idx;
  logic [11:0]       tx;
  logic              tx_in;
  logic [8:0]        wr_x;
  logic              wr_en;
  logic              issue;
  logic              unused_msbs;

  // Bit 15 of every 16-bit group carries no pixel.
  assign unused_msbs = ^{ddram_dout[63], ddram_dout[47], ddram_dout[31], ddram_dout[15]};

  assign cmd_ready  = (state_q == S_IDLE) && !line_start;
  assign ddram_rd   = ddram_rd_q;
  assign ddram_addr = ddram_addr_q;
  assign busy       = busy_q;
  assign rd_pix     = rd_pix_q;
  assign rd_opaque  = rd_opaque_q;

  // Current pixel and its target X (12-bit two's complement, bit 11 = sign).
  always_comb begin
    px_idx = word_q[5*int'(j_q) +: 5];
    if (flip_q) tx = {x_q[10], x_q} + {3'b0, w_q} - 12'd1 - {3'b0, i_q};
    else        tx = {x_q[10], x_q} + {3'b0, i_q};
    tx_in = !tx[11] && (tx[10:0] < 11'(LINE_W));
    wr_x  = tx[8:0];
    wr_en = (state_q == S_WRITE) && !line_start && tx_in &&
            (px_idx != 5'h1F) && !opq_q[bank_q][wr_x];
    issue = (state_q == S_FETCH) && !line_start && !ddram_busy && !rd_pend_q;
  end

  // Next-state logic for the draw FSM, DDRAM request and opaque flags.
  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    x_d          = x_q;
    w_d          = w_q;
    pal_d        = pal_q;
    flip_d       = flip_q;
    addr_d       = addr_q;
    i_d          = i_q;
    k_d          = k_q;
    j_d          = j_q;
    word_d       = word_q;
    ddram_rd_d   = 1'b0;
    ddram_addr_d = ddram_addr_q;
    opq_d        = opq_q;
    rd_pend_d    = rd_pend_q && !ddram_dout_ready;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready && (cmd_w != 9'd0)) begin
          x_d     = cmd_x;
          w_d     = cmd_w;
          pal_d   = cmd_pal;
          flip_d  = cmd_flip;
          addr_d  = cmd_addr;
          i_d     = '0;
          k_d     = '0;
          j_d     = '0;
          state_d = S_FETCH;
        end
      end
      S_CLEAR: begin
        // Cleared even on a coincident line_start so the bank turning front
        // never shows stale flags.
        opq_d[bank_q] = '0;
        state_d       = S_IDLE;
      end
      S_FETCH: begin
        if (issue) begin
          ddram_rd_d   = 1'b1;
          ddram_addr_d = AROM_BASE + {3'b0, addr_q} + {23'b0, k_q};
          rd_pend_d    = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ddram_dout_ready) begin
          word_d  = {ddram_dout[62:48], ddram_dout[46:32], ddram_dout[30:16], ddram_dout[14:0]};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_en) opq_d[bank_q][wr_x] = 1'b1;
        i_d = i_q + 9'd1;
        if (i_q + 9'd1 == w_q) begin
          state_d = S_IDLE;
        end else if (j_q == 4'd11) begin
          j_d     = '0;
          k_d     = k_q + 6'd1;
          state_d = S_FETCH;
        end else begin
          j_d = j_q + 4'd1;
        end
      end
      default: state_d = S_CLEAR;
    endcase

    // A new line drops whatever is in flight; a read already outstanding is
    // absorbed later by rd_pend without reaching the buffer.
    if (line_start) begin
      state_d = S_CLEAR;
      bank_d  = ~bank_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Registered read port on the front bank; unwritten pixels read as zero.
  always_comb begin
    rd_opaque_d = 1'b0;
    rd_pix_d    = '0;
    if (rd_x < 9'(LINE_W)) begin
      rd_opaque_d = opq_q[~bank_q][rd_x];
      if (rd_opaque_d) rd_pix_d = pix_mem[~bank_q][rd_x];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      bank_q       <= 1'b0;
      rd_pend_q    <= 1'b0;
      x_q          <= '0;
      w_q          <= '0;
      pal_q        <= '0;
      flip_q       <= 1'b0;
      addr_q       <= '0;
      i_q          <= '0;
      k_q          <= '0;
      j_q          <= '0;
      word_q       <= '0;
      ddram_rd_q   <= 1'b0;
      ddram_addr_q <= '0;
      busy_q       <= 1'b0;
      rd_pix_q     <= '0;
      rd_opaque_q  <= 1'b0;
      opq_q[0]     <= '0;
      opq_q[1]     <= '0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      rd_pend_q    <= rd_pend_d;
      x_q          <= x_d;
      w_q          <= w_d;
      pal_q        <= pal_d;
      flip_q       <= flip_d;
      addr_q       <= addr_d;
      i_q          <= i_d;
      k_q          <= k_d;
      j_q          <= j_d;
      word_q       <= word_d;
      ddram_rd_q   <= ddram_rd_d;
      ddram_addr_q <= ddram_addr_d;
      busy_q       <= busy_d;
      rd_pix_q     <= rd_pix_d;
      rd_opaque_q  <= rd_opaque_d;
      opq_q        <= opq_d;
    end
  end

  // Pixel storage (no reset; validity is carried by the opaque flags).
  always_ff @(posedge clk) begin
    if (wr_en) pix_mem[bank_q][wr_x] <= {pal_q, px_idx};
  end

endmodule
